// File: rtl/calc_pkg.sv
// Shared definitions for the typewriter write scheduler: FSM states,
// ASCII constants and the default timeout length.
package calc_pkg;

    typedef logic [7:0] ascii_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CALC,
        STREAM,
        NEWLINE,
        ERR_Q,
        ERR_CR
    } state_t;

    localparam ascii_t ASCII_CR  = 8'h0D;
    localparam ascii_t ASCII_ERR = 8'h3F;

    localparam int TIMEOUT_CYC_DEF = 2_000_000;

endpackage

// File: rtl/calc_write_sched_if.sv
// Character/handshake bundle between the write scheduler and its neighbours:
// keyboard decoder, calculator core, bin2BCD and the result streamer.
// master = scheduler side, slave = surrounding blocks.
interface calc_write_sched_if;
    import calc_pkg::*;

    logic   kb_valid;
    ascii_t kb_ascii;
    logic   calc_finish;
    logic   res_valid;
    ascii_t res_ascii;
    logic   res_last;
    logic   calc_start;
    logic   bcd_start;
    logic   wr_valid;
    ascii_t wr_ascii;

    modport master (
        input  kb_valid, kb_ascii, calc_finish, res_valid, res_ascii, res_last,
        output calc_start, bcd_start, wr_valid, wr_ascii
    );

    modport slave (
        output kb_valid, kb_ascii, calc_finish, res_valid, res_ascii, res_last,
        input  calc_start, bcd_start, wr_valid, wr_ascii
    );

endinterface

// File: rtl/key_fifo.sv
// Small synchronous key buffer. DEPTH must be a power of two so the
// pointers wrap naturally. A push while full is accepted only when a pop
// happens in the same cycle.
module key_fifo
    import calc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  ascii_t din,
    output ascii_t dout,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ascii_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array: data only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; reset flushes the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/calc_write_sched.sv
// Typewriter write-port scheduler. Grants the single write port to keyed
// characters in IDLE and to result characters during a calculation, and
// issues the calculator / bin2BCD start pulses.
// Build option: define CALC_SCHED_KEY_FIFO_EN to buffer keys that arrive
// while busy and replay them in IDLE; otherwise such keys are dropped.
module calc_write_sched
    import calc_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    calc_write_sched_if.master  bus,
    output logic                busy,
    output logic                timeout_err,
    output logic [7:0]          drop_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state;
    logic              calc_fin_q;
    logic              calc_rise;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_hit;
    logic              key_vld;
    logic              key_drop;
    ascii_t            key_dat;

    assign calc_rise = bus.calc_finish & ~calc_fin_q;
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

`ifdef CALC_SCHED_KEY_FIFO_EN
    logic   fifo_push;
    logic   fifo_pop;
    logic   fifo_full;
    logic   fifo_empty;
    ascii_t fifo_dout;

    key_fifo #(.DEPTH(FIFO_DEPTH)) u_key_fifo (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.kb_ascii),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Key source: queued keys go first; a live key queues behind them to keep order
    always_comb begin
        fifo_pop  = (state == IDLE) && !fifo_empty;
        fifo_push = bus.kb_valid && ((state != IDLE) || !fifo_empty)
                    && (!fifo_full || fifo_pop);
        key_drop  = bus.kb_valid && (state != IDLE) && fifo_full;
        key_vld   = (state == IDLE) && (fifo_empty ? bus.kb_valid : 1'b1);
        key_dat   = fifo_empty ? bus.kb_ascii : fifo_dout;
    end
`else
    // Key source: live keys only; anything arriving while busy is lost
    always_comb begin
        key_vld  = (state == IDLE) && bus.kb_valid;
        key_dat  = bus.kb_ascii;
        key_drop = (state != IDLE) && bus.kb_valid;
    end
`endif

    // Scheduler FSM with registered strobes, status and drop counter
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            calc_fin_q     <= 1'b0;
            tmo_cnt        <= '0;
            bus.wr_valid   <= 1'b0;
            bus.wr_ascii   <= '0;
            bus.calc_start <= 1'b0;
            bus.bcd_start  <= 1'b0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            calc_fin_q     <= bus.calc_finish;
            bus.wr_valid   <= 1'b0;
            bus.calc_start <= 1'b0;
            bus.bcd_start  <= 1'b0;
            if (key_drop) drop_cnt <= sat_inc8(drop_cnt);

            case (state)
                IDLE: begin
                    if (key_vld) begin
                        bus.wr_valid <= 1'b1;
                        bus.wr_ascii <= key_dat;
                        if (key_dat == ASCII_CR) begin
                            bus.calc_start <= 1'b1;
                            tmo_cnt        <= '0;
                            busy           <= 1'b1;
                            state          <= WAIT_CALC;
                        end
                    end
                end
                WAIT_CALC: begin
                    if (calc_rise) begin
                        bus.bcd_start <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= STREAM;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ERR_Q;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                STREAM: begin
                    if (bus.res_valid) begin
                        bus.wr_valid <= 1'b1;
                        bus.wr_ascii <= bus.res_ascii;
                    end
                    if (bus.res_valid && bus.res_last) begin
                        state <= NEWLINE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        state       <= ERR_Q;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                NEWLINE: begin
                    bus.wr_valid <= 1'b1;
                    bus.wr_ascii <= ASCII_CR;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                ERR_Q: begin
                    bus.wr_valid <= 1'b1;
                    bus.wr_ascii <= ASCII_ERR;
                    state        <= ERR_CR;
                end
                ERR_CR: begin
                    bus.wr_valid <= 1'b1;
                    bus.wr_ascii <= ASCII_CR;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_write_sched.sv
// Self-checking bench for calc_write_sched: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a queue-based
// behavioural model. Honours CALC_SCHED_KEY_FIFO_EN the same way the design does.
module tb_calc_write_sched;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 40;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       busy;
    logic       timeout_err;
    logic [7:0] drop_cnt;

    calc_write_sched_if bus ();

    calc_write_sched #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_50m     (clk_50m),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err),
        .drop_cnt    (drop_cnt)
    );

    always #10 clk_50m = ~clk_50m;

    // Reference model state
    typedef enum int {P_IDLE, P_CALC, P_STREAM, P_NL, P_ERRQ, P_ERRCR} phase_t;
    phase_t     ph;
    logic [7:0] key_q [$];
    int         cyc_in_ph;
    bit         fin_prev;
    bit         e_wr_valid, e_calc_start, e_bcd_start, e_tmo;
    logic [7:0] e_wr_ascii;
    int         e_drop;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE;
        key_q.delete();
        cyc_in_ph = 0;
        fin_prev = 1'b0;
        e_wr_valid = 1'b0; e_calc_start = 1'b0; e_bcd_start = 1'b0; e_tmo = 1'b0;
        e_wr_ascii = 8'h00;
        e_drop = 0;
    endtask

    task automatic emit(input logic [7:0] c);
        e_wr_valid = 1'b1;
        e_wr_ascii = c;
    endtask

    task automatic count_drop();
        if (e_drop < 255) e_drop++;
    endtask

    task automatic stay_or_timeout();
        cyc_in_ph++;
        if (cyc_in_ph == TIMEOUT_CYC) begin
            e_tmo = 1'b1;
            ph = P_ERRQ;
        end
    endtask

    // One clock of expected behaviour, evaluated from the inputs seen at the edge
    task automatic model_step();
        logic [7:0] k;
        bit have, idle, rise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        rise = bus.calc_finish && !fin_prev;
        fin_prev = bus.calc_finish;
        e_wr_valid = 1'b0; e_calc_start = 1'b0; e_bcd_start = 1'b0;
        idle = (ph == P_IDLE);
        have = 1'b0;
        k = 8'h00;
`ifdef CALC_SCHED_KEY_FIFO_EN
        if (idle && key_q.size() > 0) begin
            k = key_q.pop_front();
            have = 1'b1;
            if (bus.kb_valid) key_q.push_back(bus.kb_ascii);
        end else if (idle && bus.kb_valid) begin
            k = bus.kb_ascii;
            have = 1'b1;
        end else if (bus.kb_valid) begin
            if (key_q.size() < FIFO_DEPTH) key_q.push_back(bus.kb_ascii);
            else count_drop();
        end
`else
        if (bus.kb_valid) begin
            if (idle) begin
                k = bus.kb_ascii;
                have = 1'b1;
            end else begin
                count_drop();
            end
        end
`endif
        case (ph)
            P_IDLE: if (have) begin
                emit(k);
                if (k == 8'h0D) begin
                    e_calc_start = 1'b1;
                    ph = P_CALC;
                    cyc_in_ph = 0;
                end
            end
            P_CALC: if (rise) begin
                e_bcd_start = 1'b1;
                ph = P_STREAM;
                cyc_in_ph = 0;
            end else stay_or_timeout();
            P_STREAM: begin
                if (bus.res_valid) emit(bus.res_ascii);
                if (bus.res_valid && bus.res_last) ph = P_NL;
                else stay_or_timeout();
            end
            P_NL:    begin emit(8'h0D); ph = P_IDLE; end
            P_ERRQ:  begin emit(8'h3F); ph = P_ERRCR; end
            P_ERRCR: begin emit(8'h0D); ph = P_IDLE; end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_50m);
        model_step();
        @(negedge clk_50m);
        chk("wr_valid",    bus.wr_valid,   e_wr_valid);
        chk("wr_ascii",    bus.wr_ascii,   e_wr_ascii);
        chk("calc_start",  bus.calc_start, e_calc_start);
        chk("bcd_start",   bus.bcd_start,  e_bcd_start);
        chk("busy",        busy,           ph != P_IDLE);
        chk("timeout_err", timeout_err,    e_tmo);
        chk("drop_cnt",    drop_cnt,       e_drop);
    endtask

    task automatic key(input logic [7:0] c);
        bus.kb_valid = 1'b1;
        bus.kb_ascii = c;
        tick();
        bus.kb_valid = 1'b0;
    endtask

    task automatic res(input logic [7:0] c, input bit last);
        bus.res_valid = 1'b1;
        bus.res_ascii = c;
        bus.res_last  = last;
        tick();
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.calc_finish = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic finish_pulse();
        bus.calc_finish = 1'b1;
        tick();
        chk("bcd_after_finish", bus.bcd_start, 1'b1);
        bus.calc_finish = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.kb_valid = 1'b0; bus.kb_ascii = 8'h00;
        bus.calc_finish = 1'b0;
        bus.res_valid = 1'b0; bus.res_ascii = 8'h00; bus.res_last = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        chk("rst_wr_valid", bus.wr_valid, 1'b0);
        chk("rst_wr_ascii", bus.wr_ascii, 8'h00);
        chk("rst_busy",     busy,         1'b0);
        chk("rst_drop",     drop_cnt,     8'd0);

        // Keys pass through
        key(8'h31); chk("pass_1", bus.wr_ascii, 8'h31); chk("pass_1_vld", bus.wr_valid, 1'b1);
        tick();
        key(8'h2B); chk("pass_plus", bus.wr_ascii, 8'h2B);
        key(8'h32); chk("pass_2", bus.wr_ascii, 8'h32); chk("pass_busy", busy, 1'b0);
        tick();

        // Enter starts a calculation, result streams back
        key(8'h0D);
        chk("enter_wr", bus.wr_ascii, 8'h0D);
        chk("enter_calc_start", bus.calc_start, 1'b1);
        repeat (3) tick();
        finish_pulse();
        tick();
        res(8'h33, 1'b1); chk("res_3", bus.wr_ascii, 8'h33);
        tick(); chk("res_cr", bus.wr_ascii, 8'h0D); chk("res_cr_vld", bus.wr_valid, 1'b1);
        chk("res_idle", busy, 1'b0);
        tick();

        // Keys during a calculation
        do_reset();
        key(8'h0D);
        key(8'h34);
        key(8'h35);
        finish_pulse();
        res(8'h37, 1'b1);
        tick(); chk("busy_cr", bus.wr_ascii, 8'h0D);
        tick();
`ifdef CALC_SCHED_KEY_FIFO_EN
        chk("replay_4", bus.wr_ascii, 8'h34); chk("replay_4_vld", bus.wr_valid, 1'b1);
        tick();
        chk("replay_5", bus.wr_ascii, 8'h35); chk("replay_5_vld", bus.wr_valid, 1'b1);
`else
        chk("nofifo_quiet", bus.wr_valid, 1'b0); chk("nofifo_drop", drop_cnt, 8'd2);
        tick();
`endif
        tick();

        // Timeout waiting for the calculator
        do_reset();
        key(8'h0D);
        repeat (TIMEOUT_CYC - 1) tick();
        chk("tmo_not_yet", timeout_err, 1'b0);
        tick(); chk("tmo_flag", timeout_err, 1'b1);
        tick(); chk("tmo_q", bus.wr_ascii, 8'h3F); chk("tmo_q_vld", bus.wr_valid, 1'b1);
        tick(); chk("tmo_cr", bus.wr_ascii, 8'h0D);
        tick();
        key(8'h41); chk("tmo_key_after", bus.wr_ascii, 8'h41); chk("tmo_sticky", timeout_err, 1'b1);
        tick();

        // Asynchronous reset in STREAM
        do_reset();
        key(8'h0D);
        finish_pulse();
        res(8'h39, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_wr_valid", bus.wr_valid, 1'b0);
        chk("arst_wr_ascii", bus.wr_ascii, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;

        // Overflow of the key buffer while busy
        key(8'h0D);
        for (int i = 0; i < 6; i++) key(8'h61 + 8'(i));
`ifdef CALC_SCHED_KEY_FIFO_EN
        chk("ovf_drop", drop_cnt, 8'd2);
`else
        chk("ovf_drop", drop_cnt, 8'd6);
`endif
        finish_pulse();
        res(8'h30, 1'b1);
        tick();
`ifdef CALC_SCHED_KEY_FIFO_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ovf_replay", bus.wr_ascii, 8'h61 + 8'(i));
        end
`endif
        repeat (3) tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bus.kb_valid  = ($urandom_range(0, 3) == 0);
            bus.kb_ascii  = ($urandom_range(0, 6) == 0) ? 8'h0D : 8'($urandom_range(8'h30, 8'h39));
            if ($urandom_range(0, 7) == 0) bus.calc_finish = ~bus.calc_finish;
            bus.res_valid = ($urandom_range(0, 2) == 0);
            bus.res_ascii = 8'($urandom_range(8'h20, 8'h7E));
            bus.res_last  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
        bus.kb_valid = 1'b0;
        bus.res_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
